channel_unpack: RTL and testbench

CHANNEL_UNPACK -- requirements
Module: channel_unpack

---
 rtl/channel_unpack.sv | 104 ++++++++++
 tb/tb_channel_unpack.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/channel_unpack.sv
// rtl/channel_unpack.sv - splits a WIDTH*COUNT word into COUNT narrow beats, LSB slice first
// Optional out_last output enabled by defining CHANNEL_UNPACK_LAST_EN.
module channel_unpack #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH*COUNT-1:0]   in_dat,
    input  logic                     in_val,
    output logic                     in_rdy,
    output logic [WIDTH-1:0]         out_dat,
    output logic                     out_val,
    input  logic                     out_rdy
`ifdef CHANNEL_UNPACK_LAST_EN
    ,
    output logic                     out_last
`endif
);

    localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH*COUNT-1:0]   word_q, word_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [WIDTH-1:0]         dat_q, dat_d;
    logic [IDX_W-1:0]         idx_inc;
    logic                     is_last;
    logic                     in_acc;
    logic                     out_xfer;
`ifdef CHANNEL_UNPACK_LAST_EN
    logic                     last_q, last_d;
`endif

    assign is_last = (idx_q == LAST_IDX);
    assign idx_inc = idx_q + 1'b1;
    assign out_val = (state_q == BUSY);
    assign out_dat = dat_q;
    assign in_rdy  = !out_val || (out_rdy && is_last);
    assign in_acc  = in_val && in_rdy;
    assign out_xfer = out_val && out_rdy;
`ifdef CHANNEL_UNPACK_LAST_EN
    assign out_last = last_q;
`endif

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
`ifdef CHANNEL_UNPACK_LAST_EN
        last_d  = last_q;
`endif
        if (out_xfer && !is_last) begin
            // Shift rather than part-select so COUNT=1 never elaborates an out-of-range slice.
            idx_d = idx_inc;
            dat_d = WIDTH'(word_q >> (WIDTH * int'(idx_inc)));
`ifdef CHANNEL_UNPACK_LAST_EN
            last_d = (idx_inc == LAST_IDX);
`endif
        end else if (in_acc) begin
            state_d = BUSY;
            word_d  = in_dat;
            idx_d   = '0;
            dat_d   = in_dat[WIDTH-1:0];
`ifdef CHANNEL_UNPACK_LAST_EN
            last_d  = (COUNT == 1);
`endif
        end else if (out_xfer) begin
            state_d = EMPTY;
            idx_d   = '0;
`ifdef CHANNEL_UNPACK_LAST_EN
            last_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            word_q  <= '0;
            idx_q   <= '0;
            dat_q   <= '0;
`ifdef CHANNEL_UNPACK_LAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
`ifdef CHANNEL_UNPACK_LAST_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_channel_unpack.sv
// tb/tb_channel_unpack.sv - directed checks for channel_unpack (COUNT=4) plus a COUNT=1 random pass-through
module tb_channel_unpack;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] in_dat;
    logic        in_val;
    logic        in_rdy;
    logic [7:0]  out_dat;
    logic        out_val;
    logic        out_rdy;

    logic [7:0]  s_in_dat;
    logic        s_in_val;
    logic        s_in_rdy;
    logic [7:0]  s_out_dat;
    logic        s_out_val;
    logic        s_out_rdy;

`ifdef CHANNEL_UNPACK_LAST_EN
    logic        out_last;
    logic        s_out_last;
`endif

    channel_unpack #(.WIDTH(8), .COUNT(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_dat  (in_dat),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .out_dat (out_dat),
        .out_val (out_val),
        .out_rdy (out_rdy)
`ifdef CHANNEL_UNPACK_LAST_EN
        ,
        .out_last(out_last)
`endif
    );

    channel_unpack #(.WIDTH(8), .COUNT(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_dat  (s_in_dat),
        .in_val  (s_in_val),
        .in_rdy  (s_in_rdy),
        .out_dat (s_out_dat),
        .out_val (s_out_val),
        .out_rdy (s_out_rdy)
`ifdef CHANNEL_UNPACK_LAST_EN
        ,
        .out_last(s_out_last)
`endif
    );

    int checks   = 0;
    int failures = 0;

    localparam logic [7:0] B2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    int pushed;
    int popped;

    initial begin
        rst_n = 1'b0; in_dat = '0; in_val = 1'b0; out_rdy = 1'b0;
        s_in_dat = '0; s_in_val = 1'b0; s_out_rdy = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_out_val", out_val, 0);
        check("rst_out_dat", out_dat, 0);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_c1_val", s_out_val, 0);
`ifdef CHANNEL_UNPACK_LAST_EN
        check("rst_last", out_last, 0);
`endif

        // single word, consumer always ready
        in_dat = 32'h44332211; in_val = 1'b1; out_rdy = 1'b1;
        #1;
        check("t1_in_rdy", in_rdy, 1);
        tick();
        in_val = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t1_val", out_val, 1);
            check("t1_dat", out_dat, B2[i]);
            tick(); #1;
        end
        check("t1_empty", out_val, 0);

        // two words back to back
        in_dat = 32'h44332211; in_val = 1'b1;
        tick();
        in_dat = 32'h88776655;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) in_val = 1'b0;
            #1;
            check("t2_val", out_val, 1);
            check("t2_dat", out_dat, B2[i]);
            check("t2_in_rdy", in_rdy, (i == 3 || i == 7) ? 1 : 0);
`ifdef CHANNEL_UNPACK_LAST_EN
            check("t2_last", out_last, (i == 3 || i == 7) ? 1 : 0);
`endif
            tick();
        end
        check("t2_empty", out_val, 0);

        // backpressure on beat 0x22
        in_dat = 32'h44332211; in_val = 1'b1;
        tick();
        in_val = 1'b0;
        tick();
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_hold_dat", out_dat, 8'h22);
            check("t3_hold_val", out_val, 1);
            check("t3_hold_in_rdy", in_rdy, 0);
            tick();
        end
        out_rdy = 1'b1;
        #1;
        check("t3_still_22", out_dat, 8'h22);
        tick();
        check("t3_next_33", out_dat, 8'h33);
        tick();
        check("t3_next_44", out_dat, 8'h44);
        tick();
        check("t3_empty", out_val, 0);

        // reset mid-word, with an input offered during the reset edge
        in_dat = 32'h44332211; in_val = 1'b1;
        tick();
        in_val = 1'b0;
        tick();
        check("t4_pre_22", out_dat, 8'h22);
        rst_n = 1'b0; in_dat = 32'h12345678; in_val = 1'b1;
        tick();
        rst_n = 1'b1; in_val = 1'b0;
        #1;
        check("t4_val", out_val, 0);
        check("t4_dat", out_dat, 0);
        check("t4_in_rdy", in_rdy, 1);
        in_dat = 32'hDDCCBBAA; in_val = 1'b1;
        tick();
        in_val = 1'b0;
        check("t4_aa", out_dat, 8'hAA);
        check("t4_aa_val", out_val, 1);
        tick();
        check("t4_bb", out_dat, 8'hBB);
        tick(); tick(); tick();
        check("t4_empty", out_val, 0);

        // COUNT=1 random handshake scoreboard
        pushed = 0; popped = 0;
        for (int c = 0; c < 1000; c++) begin
            s_in_val  = 1'($urandom_range(0, 1));
            s_out_rdy = 1'($urandom_range(0, 1));
            s_in_dat  = 8'($urandom);
            #1;
            if (s_out_val && s_out_rdy) begin
                if (q.size() == 0) check("c1_extra_beat", 1, 0);
                else begin
                    check("c1_dat", s_out_dat, q.pop_front());
                    popped++;
                end
            end
            if (s_in_val && s_in_rdy) begin
                q.push_back(s_in_dat);
                pushed++;
            end
            tick();
        end
        s_in_val = 1'b0; s_out_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (s_out_val) begin
                if (q.size() == 0) check("c1_extra_beat", 1, 0);
                else begin
                    check("c1_drain_dat", s_out_dat, q.pop_front());
                    popped++;
                end
            end
            tick();
        end
        check("c1_lost", q.size(), 0);
        check("c1_count", popped, pushed);
        check("c1_empty", s_out_val, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
